// File: rtl/cory_mux_arb_if.sv
// Bundle of request, select and grant signals between the arbiter and its requesters/mux.
// The slave modport is the arbiter side; the master modport is the requester/mux side.
interface cory_mux_arb_if #(
  parameter int R = 4
) ();
  localparam int S = (R <= 2) ? 1 : (R <= 4) ? 2 : (R <= 8) ? 3 : 4;

  logic [R-1:0] i_req;
  logic [R-1:0] i_last;
  logic         o_s_v;
  logic [S-1:0] o_s_d;
  logic         i_s_r;
  logic [R-1:0] o_gnt;
  logic         o_busy;

  modport master (
    output i_req, i_last, i_s_r,
    input  o_s_v, o_s_d, o_gnt, o_busy
  );

  modport slave (
    input  i_req, i_last, i_s_r,
    output o_s_v, o_s_d, o_gnt, o_busy
  );
endinterface

// File: rtl/cory_mux_arb.sv
// Round-robin burst arbiter driving the select channel of an R-way cory_mux.
// A grant is held for up to B select beats, or until the granted requester's last beat.
module cory_mux_arb #(
  parameter int R = 4,
  parameter int B = 4
) (
  input  logic            clk,
  input  logic            reset,
  cory_mux_arb_if.slave   bus
);
  localparam int S = (R <= 2) ? 1 : (R <= 4) ? 2 : (R <= 8) ? 3 : 4;
  localparam int C = $clog2(B + 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t       state_q, state_d;
  logic [S-1:0] sel_q, sel_d;
  logic [S-1:0] ptr_q, ptr_d;
  logic [C-1:0] cnt_q, cnt_d;
  logic [R-1:0] gnt_q, gnt_d;
  logic         busy_q, busy_d;

  logic         req_sel_s;
  logic         last_sel_s;
  logic         s_v_s;
  logic         beat_s;
  logic         release_s;
  logic [S-1:0] pick_s;
  logic [S-1:0] sel_inc_s;

  // First requester at or above ptr, wrapping at R rather than at 2^S.
  function automatic logic [S-1:0] rr_pick(input logic [R-1:0] req, input logic [S-1:0] ptr);
    logic         found;
    logic [S-1:0] res;
    int           idx;
    found = 1'b0;
    res   = '0;
    for (int k = 0; k < R; k++) begin
      idx = (int'(ptr) + k) % R;
      if (!found && req[idx]) begin
        found = 1'b1;
        res   = S'(idx);
      end
    end
    return res;
  endfunction

  function automatic logic [R-1:0] onehot(input logic [S-1:0] idx);
    logic [R-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  assign req_sel_s  = bus.i_req[sel_q];
  assign last_sel_s = bus.i_last[sel_q];
  assign s_v_s      = (state_q == GRANT) && req_sel_s;
  assign beat_s     = s_v_s && bus.i_s_r;
  assign pick_s     = rr_pick(bus.i_req, ptr_q);
  assign sel_inc_s  = (sel_q == S'(R - 1)) ? S'(0) : sel_q + S'(1);

  // A dropped request can only release without a beat, since a beat needs the request.
  assign release_s  = (beat_s && (last_sel_s || (cnt_q == C'(B - 1)))) || !req_sel_s;

  // Next-state, pointer, beat counter and registered grant/busy decode.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.i_req != '0) begin
          sel_d   = pick_s;
          cnt_d   = '0;
          state_d = GRANT;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (release_s) begin
          state_d = IDLE;
          ptr_d   = sel_inc_s;
          cnt_d   = '0;
        end else if (beat_s) begin
          cnt_d   = cnt_q + C'(1);
        end else begin
          cnt_d   = cnt_q;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d == GRANT);
    if (busy_d) begin
      gnt_d = onehot(sel_d);
    end else begin
      gnt_d = '0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.o_s_v  = s_v_s;
  assign bus.o_s_d  = sel_q;
  assign bus.o_gnt  = gnt_q;
  assign bus.o_busy = busy_q;
endmodule

// File: tb/tb_cory_mux_arb.sv
// Directed bench for cory_mux_arb: cycle table for R=4,B=4 plus a hand sequence for R=3,B=1.
module tb_cory_mux_arb;
  logic clk;
  logic reset;

  int checks;
  int errors;

  cory_mux_arb_if #(.R(4)) bus4 ();
  cory_mux_arb_if #(.R(3)) bus3 ();

  cory_mux_arb #(.R(4), .B(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
  cory_mux_arb #(.R(3), .B(1)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] last;
    logic       sr;
    logic       ev;
    logic [1:0] ed;
    logic [3:0] eg;
    logic       eb;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic [3:0] req, input logic [3:0] last,
                     input logic sr, input logic ev, input logic [1:0] ed,
                     input logic [3:0] eg, input logic eb);
    vec_t v;
    v.rst = rst; v.req = req; v.last = last; v.sr = sr;
    v.ev = ev; v.ed = ed; v.eg = eg; v.eb = eb;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int row, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d got %0h expected %0h", name, row, act, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus4.i_req = '0; bus4.i_last = '0; bus4.i_s_r = 1'b0;
    bus3.i_req = '0; bus3.i_last = '0; bus3.i_s_r = 1'b0;

    // Reset with all requesting, then round robin 0,1,2,3,0 with 4-beat bursts.
    add(1'b1, 4'hF, 4'h0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0);
    add(1'b0, 4'hF, 4'h0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0);
    for (int g = 0; g < 4; g++) begin
      for (int b = 0; b < 4; b++)
        add(1'b0, 4'hF, 4'h0, 1'b1, 1'b1, 2'(g), 4'(1 << g), 1'b1);
      add(1'b0, 4'hF, 4'h0, 1'b1, 1'b0, 2'(g), 4'h0, 1'b0);
    end
    add(1'b0, 4'hF, 4'h0, 1'b1, 1'b1, 2'd0, 4'h1, 1'b1);
    add(1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 2'd0, 4'h1, 1'b1);
    add(1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0);
    // Requester 2 alone, last on beat 2, then 4'b1001 grants requester 3.
    add(1'b0, 4'h4, 4'h0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0);
    add(1'b0, 4'h4, 4'h0, 1'b1, 1'b1, 2'd2, 4'h4, 1'b1);
    add(1'b0, 4'h4, 4'h4, 1'b1, 1'b1, 2'd2, 4'h4, 1'b1);
    add(1'b0, 4'h9, 4'h0, 1'b1, 1'b0, 2'd2, 4'h0, 1'b0);
    add(1'b0, 4'h9, 4'h8, 1'b1, 1'b1, 2'd3, 4'h8, 1'b1);
    add(1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 2'd3, 4'h0, 1'b0);
    // Backpressure 1,0,0,1,1,0,1; a last flag without a beat is ignored.
    add(1'b0, 4'h1, 4'h0, 1'b1, 1'b0, 2'd3, 4'h0, 1'b0);
    add(1'b0, 4'h1, 4'h0, 1'b1, 1'b1, 2'd0, 4'h1, 1'b1);
    add(1'b0, 4'h1, 4'h1, 1'b0, 1'b1, 2'd0, 4'h1, 1'b1);
    add(1'b0, 4'h1, 4'h0, 1'b0, 1'b1, 2'd0, 4'h1, 1'b1);
    add(1'b0, 4'h1, 4'h0, 1'b1, 1'b1, 2'd0, 4'h1, 1'b1);
    add(1'b0, 4'h1, 4'h0, 1'b1, 1'b1, 2'd0, 4'h1, 1'b1);
    add(1'b0, 4'h1, 4'h0, 1'b0, 1'b1, 2'd0, 4'h1, 1'b1);
    add(1'b0, 4'h1, 4'h0, 1'b1, 1'b1, 2'd0, 4'h1, 1'b1);
    // Wrap pick from ptr=1 to requester 0, then a dropped request releases.
    add(1'b0, 4'h1, 4'h0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0);
    add(1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 2'd0, 4'h1, 1'b1);
    add(1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0);
    // Mid-burst reset during a grant to requester 1; next grant is requester 0.
    add(1'b0, 4'h2, 4'h0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0);
    add(1'b0, 4'h2, 4'h0, 1'b1, 1'b1, 2'd1, 4'h2, 1'b1);
    add(1'b0, 4'h2, 4'h0, 1'b1, 1'b1, 2'd1, 4'h2, 1'b1);
    add(1'b1, 4'h2, 4'h0, 1'b1, 1'b1, 2'd1, 4'h2, 1'b1);
    add(1'b0, 4'hF, 4'h0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0);
    add(1'b0, 4'hF, 4'h0, 1'b1, 1'b1, 2'd0, 4'h1, 1'b1);
    add(1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 2'd0, 4'h1, 1'b1);
    add(1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      reset       = vecs[i].rst;
      bus4.i_req  = vecs[i].req;
      bus4.i_last = vecs[i].last;
      bus4.i_s_r  = vecs[i].sr;
      #1;
      chk("s_v",  i, 16'(bus4.o_s_v),  16'(vecs[i].ev));
      chk("s_d",  i, 16'(bus4.o_s_d),  16'(vecs[i].ed));
      chk("gnt",  i, 16'(bus4.o_gnt),  16'(vecs[i].eg));
      chk("busy", i, 16'(bus4.o_busy), 16'(vecs[i].eb));
      @(posedge clk);
      #1;
    end

    // R=3, B=1: grants alternate with idle bubbles, order 0,1,2,0,1.
    reset      = 1'b1;
    bus4.i_req = '0;
    bus3.i_req = 3'b111;
    bus3.i_s_r = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    begin
      logic [1:0] exp_sel;
      exp_sel = 2'd0;
      for (int c = 0; c < 10; c++) begin
        #1;
        if (c % 2 == 1) begin
          exp_sel = 2'(((c - 1) / 2) % 3);
          chk("r3_s_v", 100 + c, 16'(bus3.o_s_v), 16'd1);
          chk("r3_gnt", 100 + c, 16'(bus3.o_gnt), 16'(3'b001 << exp_sel));
        end else begin
          chk("r3_s_v", 100 + c, 16'(bus3.o_s_v), 16'd0);
          chk("r3_gnt", 100 + c, 16'(bus3.o_gnt), 16'd0);
        end
        chk("r3_s_d", 100 + c, 16'(bus3.o_s_d), 16'(exp_sel));
        chk("r3_s_d_range", 100 + c, 16'(bus3.o_s_d < 2'd3), 16'd1);
        @(posedge clk);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
